// File: rtl/vc_egress_arbiter_pkg.sv
// Shared definitions for the VC egress arbiter: FSM encoding, routing bit
// position and push counter width.
package vc_egress_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } arb_state_e;

  // Bit of the popped word that picks the destination (0 -> D0, 1 -> D1).
  localparam int ROUTE_BIT = 4;
  localparam int CNT_W     = 8;

endpackage

// File: rtl/vc_route_stage.sv
// Two-stage pop-to-push pipeline: stage 1 holds the in-flight tag, stage 2
// captures the FIFO head, routes it, and drives the registered push strobes.
module vc_route_stage
  import vc_egress_arbiter_pkg::*;
#(
  parameter int data_width = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pop0_i,
  input  logic                  pop1_i,
  input  logic [data_width-1:0] data_vc0_i,
  input  logic [data_width-1:0] data_vc1_i,
  output logic                  push_d0_o,
  output logic                  push_d1_o,
  output logic [data_width-1:0] data_o,
  output logic                  in_flight_o
);

  logic                  tag_v_q;
  logic                  tag_src_q;
  logic                  push_d0_q;
  logic                  push_d1_q;
  logic [data_width-1:0] data_q;
  logic [data_width-1:0] word;

  // The FIFO head is only valid in the cycle after its pop, i.e. while the tag is live.
  assign word = tag_src_q ? data_vc1_i : data_vc0_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_v_q   <= 1'b0;
      tag_src_q <= 1'b0;
      push_d0_q <= 1'b0;
      push_d1_q <= 1'b0;
      data_q    <= '0;
    end else begin
      tag_v_q   <= pop0_i | pop1_i;
      tag_src_q <= pop1_i;
      push_d0_q <= tag_v_q & ~word[ROUTE_BIT];
      push_d1_q <= tag_v_q & word[ROUTE_BIT];
      if (tag_v_q) begin
        data_q <= word;
      end
    end
  end

  assign push_d0_o   = push_d0_q;
  assign push_d1_o   = push_d1_q;
  assign data_o      = data_q;
  assign in_flight_o = tag_v_q | push_d0_q | push_d1_q;

endmodule

// File: rtl/vc_egress_arbiter.sv
// Strict-priority arbiter draining two VC FIFOs into two destination FIFOs,
// with a lifecycle FSM, overflow detection and per-destination push counters.
module vc_egress_arbiter
  import vc_egress_arbiter_pkg::*;
#(
  parameter int data_width = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [data_width-1:0] data_VC0,
  input  logic [data_width-1:0] data_VC1,
  input  logic                  empty_VC0,
  input  logic                  empty_VC1,
  input  logic                  almost_full_D0,
  input  logic                  almost_full_D1,
  input  logic                  full_D0,
  input  logic                  full_D1,
  output logic                  pop_VC0,
  output logic                  pop_VC1,
  output logic                  push_D0,
  output logic                  push_D1,
  output logic [data_width-1:0] data_out,
  output logic                  idle,
  output logic                  error_out,
  output logic [CNT_W-1:0]      cnt_D0,
  output logic [CNT_W-1:0]      cnt_D1,
  output arb_state_e            state_o
);

  // Handshake: pop_VCx is a combinational read strobe; the FIFO presents the word
  // on data_VCx in the following cycle. push_Dx is a registered write strobe with
  // data_out valid in the same cycle; almost_full_Dx stops new pops immediately.

  arb_state_e       state_q, state_d;
  logic             eligible;
  logic             in_flight;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE:   if (!empty_VC0 || !empty_VC1) state_d = ST_ACTIVE;
      ST_ACTIVE: if (empty_VC0 && empty_VC1 && !in_flight) state_d = ST_IDLE;
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_RESET;
    endcase
    // Writing into a full destination is unrecoverable short of reset.
    if (state_q != ST_RESET && ((push_D0 && full_D0) || (push_D1 && full_D1))) begin
      state_d = ST_ERROR;
    end
  end

  assign eligible = !reset && (state_q == ST_IDLE || state_q == ST_ACTIVE) &&
                    !almost_full_D0 && !almost_full_D1;
  assign pop_VC0  = eligible && !empty_VC0;
  assign pop_VC1  = eligible && empty_VC0 && !empty_VC1;

  vc_route_stage #(
    .data_width(data_width)
  ) u_route (
    .clk        (clk),
    .reset      (reset),
    .pop0_i     (pop_VC0),
    .pop1_i     (pop_VC1),
    .data_vc0_i (data_VC0),
    .data_vc1_i (data_VC1),
    .push_d0_o  (push_D0),
    .push_d1_o  (push_D1),
    .data_o     (data_out),
    .in_flight_o(in_flight)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (push_D0) cnt0_q <= cnt0_q + CNT_W'(1);
      if (push_D1) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign cnt_D0    = cnt0_q;
  assign cnt_D1    = cnt1_q;
  assign idle      = !reset && state_q == ST_IDLE && !in_flight;
  assign error_out = !reset && state_q == ST_ERROR;
  assign state_o   = state_q;

endmodule

// File: tb/tb_vc_egress_arbiter.sv
// Bench for vc_egress_arbiter: queue-backed VC FIFO model, a per-cycle
// reference monitor (priority, 2-cycle latency, routing, counters), a table of
// pop-eligibility vectors and hand-written corner sequences.
module tb_vc_egress_arbiter;
  import vc_egress_arbiter_pkg::*;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         init = 1'b1;
  logic [W-1:0] data_VC0 = '0;
  logic [W-1:0] data_VC1 = '0;
  logic         empty_VC0 = 1'b1;
  logic         empty_VC1 = 1'b1;
  logic         almost_full_D0 = 1'b0;
  logic         almost_full_D1 = 1'b0;
  logic         full_D0 = 1'b0;
  logic         full_D1 = 1'b0;
  logic         pop_VC0, pop_VC1, push_D0, push_D1, idle, error_out;
  logic [W-1:0] data_out;
  logic [7:0]   cnt_D0, cnt_D1;
  arb_state_e   state_o;

  vc_egress_arbiter #(.data_width(W)) dut (
    .clk(clk), .reset(reset), .init(init),
    .data_VC0(data_VC0), .data_VC1(data_VC1),
    .empty_VC0(empty_VC0), .empty_VC1(empty_VC1),
    .almost_full_D0(almost_full_D0), .almost_full_D1(almost_full_D1),
    .full_D0(full_D0), .full_D1(full_D1),
    .pop_VC0(pop_VC0), .pop_VC1(pop_VC1),
    .push_D0(push_D0), .push_D1(push_D1),
    .data_out(data_out), .idle(idle), .error_out(error_out),
    .cnt_D0(cnt_D0), .cnt_D1(cnt_D1), .state_o(state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  // ---------------- VC FIFO model ----------------
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic         ovr_en = 1'b0, ovr_e0 = 1'b1, ovr_e1 = 1'b1;
  logic         pop0_s = 1'b0, pop1_s = 1'b0;

  always @(negedge clk) begin
    pop0_s = pop_VC0;
    pop1_s = pop_VC1;
  end

  always @(posedge clk) begin
    #1;
    if (pop0_s) begin
      if (q0.size() > 0) data_VC0 = q0.pop_front();
      else data_VC0 = '0;
    end
    if (pop1_s) begin
      if (q1.size() > 0) data_VC1 = q1.pop_front();
      else data_VC1 = '0;
    end
    empty_VC0 = ovr_en ? ovr_e0 : (q0.size() == 0);
    empty_VC1 = ovr_en ? ovr_e1 : (q1.size() == 0);
  end

  // ---------------- reference monitor / scoreboard ----------------
  typedef struct packed {
    logic         v;
    logic [W-1:0] w;
  } ent_t;

  ent_t       pipe[$];
  logic [7:0] m_cnt0, m_cnt1;
  logic [W-1:0] m_last;
  logic       chk_en = 1'b0;

  task automatic arm_model();
    pipe.delete();
    pipe.push_back('0);
    pipe.push_back('0);
    m_cnt0 = '0;
    m_cnt1 = '0;
    m_last = '0;
    chk_en = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    logic elig, e_p0, e_p1;
    ent_t cur, nxt;
    if (chk_en) begin
      elig = !almost_full_D0 && !almost_full_D1;
      e_p0 = elig && !empty_VC0;
      e_p1 = elig && empty_VC0 && !empty_VC1;
      chk("pop_VC0", 32'(pop_VC0), 32'(e_p0));
      chk("pop_VC1", 32'(pop_VC1), 32'(e_p1));
      cur = pipe.pop_front();
      chk("push_D0", 32'(push_D0), 32'(cur.v && !cur.w[4]));
      chk("push_D1", 32'(push_D1), 32'(cur.v && cur.w[4]));
      if (cur.v) m_last = cur.w;
      chk("data_out", 32'(data_out), 32'(m_last));
      chk("cnt_D0", 32'(cnt_D0), 32'(m_cnt0));
      chk("cnt_D1", 32'(cnt_D1), 32'(m_cnt1));
      if (cur.v && !cur.w[4]) m_cnt0 = m_cnt0 + 8'd1;
      if (cur.v && cur.w[4])  m_cnt1 = m_cnt1 + 8'd1;
      nxt.v = e_p0 || e_p1;
      nxt.w = e_p0 ? q0[0] : (e_p1 ? q1[0] : '0);
      pipe.push_back(nxt);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    chk_en = 1'b0;
    reset = 1'b1;
    init = 1'b1;
    almost_full_D0 = 1'b0;
    almost_full_D1 = 1'b0;
    full_D0 = 1'b0;
    full_D1 = 1'b0;
    ovr_en = 1'b0;
    q0.delete();
    q1.delete();
    tick(2);
    reset = 1'b0;
    tick(3);
    init = 1'b0;
    tick(2);
    arm_model();
  endtask

  typedef struct {
    logic e0, e1, af0, af1, p0, p1;
  } vec_t;
  vec_t tbl[8];

  initial begin : watchdog
    #400000;
    errors++;
    $display("FAIL watchdog: simulation time budget exhausted");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- test sequence ----------------
  initial begin : test
    int  n0;
    logic seen, seen1;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset values, then init held 3 cycles before release.
    reset = 1'b1;
    init = 1'b1;
    tick(2);
    @(negedge clk);
    chk("rst_pop0", 32'(pop_VC0), 0);
    chk("rst_pop1", 32'(pop_VC1), 0);
    chk("rst_push0", 32'(push_D0), 0);
    chk("rst_push1", 32'(push_D1), 0);
    chk("rst_idle", 32'(idle), 0);
    chk("rst_error", 32'(error_out), 0);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_cnt0", 32'(cnt_D0), 0);
    chk("rst_cnt1", 32'(cnt_D1), 0);
    chk("rst_state", 32'(state_o), 32'(ST_RESET));
    tick(1);
    reset = 1'b0;
    tick(1);
    @(negedge clk);
    chk("init_state", 32'(state_o), 32'(ST_INIT));
    chk("init_idle", 32'(idle), 0);
    tick(2);
    init = 1'b0;
    tick(1);
    @(negedge clk);
    chk("idle_state", 32'(state_o), 32'(ST_IDLE));
    chk("idle_flag", 32'(idle), 1);
    tick(1);
    arm_model();

    // Pop eligibility table with forced empty flags.
    ovr_en = 1'b1;
    ovr_e0 = 1'b1;
    ovr_e1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      q0.push_back(W'(i));
      q1.push_back(W'(6'h30 + i));
    end
    tick(1);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ovr_e0 = tbl[i].e0;
      ovr_e1 = tbl[i].e1;
      tick(1);
      almost_full_D0 = tbl[i].af0;
      almost_full_D1 = tbl[i].af1;
      @(negedge clk);
      chk($sformatf("tbl%0d_pop0", i), 32'(pop_VC0), 32'(tbl[i].p0));
      chk($sformatf("tbl%0d_pop1", i), 32'(pop_VC1), 32'(tbl[i].p1));
    end
    ovr_en = 1'b0;
    tick(1);
    almost_full_D0 = 1'b0;
    almost_full_D1 = 1'b0;
    tick(30);

    // Two words from VC0, one per destination.
    do_reset();
    q0.push_back(6'h05);
    q0.push_back(6'h15);
    tick(8);
    @(negedge clk);
    chk("seq_cnt0", 32'(cnt_D0), 1);
    chk("seq_cnt1", 32'(cnt_D1), 1);
    chk("seq_data_out", 32'(data_out), 32'h15);
    chk("seq_idle", 32'(idle), 1);

    // Strict priority: all VC0 words before any VC1 word.
    tick(1);
    q0.push_back(6'h02);
    q0.push_back(6'h13);
    q0.push_back(6'h24);
    q1.push_back(6'h35);
    q1.push_back(6'h06);
    n0 = 0;
    seen1 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (pop_VC1) seen1 = 1'b1;
      if (pop_VC0 && !seen1) n0++;
    end
    chk("prio_vc0_count", 32'(n0), 3);
    chk("prio_vc1_seen", 32'(seen1), 1);

    // almost_full_D1 during a 4-word burst.
    tick(4);
    q0.push_back(6'h01);
    q0.push_back(6'h12);
    q0.push_back(6'h23);
    q0.push_back(6'h34);
    tick(2);
    almost_full_D1 = 1'b1;
    @(negedge clk);
    chk("af_stop", 32'(pop_VC0), 0);
    tick(3);
    almost_full_D1 = 1'b0;
    @(negedge clk);
    chk("af_resume", 32'(pop_VC0), 1);
    tick(8);

    // Randomized traffic and back-pressure.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0 && q0.size() < 6) q0.push_back(W'($urandom_range(0, 63)));
      if ($urandom_range(0, 2) == 0 && q1.size() < 6) q1.push_back(W'($urandom_range(0, 63)));
      almost_full_D0 = ($urandom_range(0, 4) == 0);
      almost_full_D1 = ($urandom_range(0, 4) == 0);
      tick(1);
    end
    almost_full_D0 = 1'b0;
    almost_full_D1 = 1'b0;
    tick(20);

    // Counter wrap: 256 words to D0.
    do_reset();
    for (int i = 0; i < 256; i++) q0.push_back(W'(i) & 6'b101111);
    tick(266);
    @(negedge clk);
    chk("wrap_cnt0", 32'(cnt_D0), 0);
    chk("wrap_cnt1", 32'(cnt_D1), 0);

    // Overflow into a full destination.
    do_reset();
    chk_en = 1'b0;
    full_D0 = 1'b1;
    q0.push_back(6'h01);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = push_D0;
    end
    chk("err_push_seen", 32'(seen), 1);
    chk("err_not_yet", 32'(error_out), 0);
    @(negedge clk);
    chk("err_set", 32'(error_out), 1);
    full_D0 = 1'b0;
    q0.push_back(6'h02);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("err_hold", 32'(error_out), 1);
      chk("err_no_pop", 32'(pop_VC0), 0);
    end
    tick(1);

    // Reset with words in flight discards them.
    do_reset();
    chk("err_cleared", 32'(error_out), 0);
    chk_en = 1'b0;
    q0.push_back(6'h03);
    q0.push_back(6'h13);
    q0.push_back(6'h07);
    q0.push_back(6'h17);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = pop_VC0;
    end
    chk("rif_pop_seen", 32'(seen), 1);
    @(negedge clk);
    reset = 1'b1;
    init = 1'b1;
    q0.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rif_push0", 32'(push_D0), 0);
      chk("rif_push1", 32'(push_D1), 0);
      chk("rif_data_out", 32'(data_out), 0);
      if (i == 1) reset = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
